instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the datapath. It takes the datapath's 16-bit pc and returns the 32-bit instr word the datapath decodes. It fetches over a req/ready memory handshake with variable wait states. A single-entry tagged buffer holds the last fetched word. The block asserts stall to freeze the datapath pc while a fetch is outstanding, and reports misaligned and timed-out fetches to the CSR/trap path.

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Memory read port of the instruction fetch unit: a req/ready handshake with wait states.
// The fetch unit is the master; the instruction memory is the slave.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one-entry tagged buffer in front of a req/ready memory port.
// Stalls the datapath while a fetch is outstanding; flags misaligned pc and fetch timeouts.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                flush,
  input  logic                trap_ack,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic                stall,
  output logic                fetch_misaligned,
  output logic                fetch_fault,
  instr_fetch_unit_if.master  mem
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StFault
  } state_e;

  localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

  state_e              state_q;
  logic                buf_valid_q;
  logic [ADDR_W-1:0]   buf_addr_q;
  logic [31:0]         buf_data_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [7:0]          wait_cnt_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                fetch_fault_q;
  logic                hit;

  // flush masks the buffer in the same cycle so a stale word is never issued
  assign hit              = buf_valid_q && (buf_addr_q == pc) && !flush;
  assign fetch_misaligned = (pc[1:0] != 2'b00);

  always_comb begin
    instr       = hit ? buf_data_q : NOP_INSTR;
    instr_valid = hit;
    stall       = !hit || fetch_misaligned || fetch_fault_q;
    fetch_fault = fetch_fault_q;
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      buf_valid_q   <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= NOP_INSTR;
      req_addr_q    <= '0;
      wait_cnt_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fetch_fault_q <= 1'b0;
    end else begin
      if (flush) begin
        buf_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!hit && !fetch_misaligned && !flush) begin
            req_addr_q <= pc;
            mem_addr_q <= pc;
            mem_req_q  <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          // Address stays put until completion even if pc is redirected meanwhile
          if (mem.mem_ready) begin
            buf_addr_q  <= req_addr_q;
            buf_data_q  <= mem.mem_rdata;
            buf_valid_q <= !flush;
            mem_req_q   <= 1'b0;
            state_q     <= StIdle;
          end else if (wait_cnt_q == LastWait) begin
            mem_req_q     <= 1'b0;
            buf_valid_q   <= 1'b0;
            fetch_fault_q <= 1'b1;
            state_q       <= StFault;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StFault: begin
          if (trap_ack) begin
            fetch_fault_q <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; bench plays the memory cycle by cycle.
module tb_instr_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        flush;
  logic        trap_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fetch_misaligned;
  logic        fetch_fault;

  int total;
  int bad;

  instr_fetch_unit_if #(.ADDR_W(16)) mem_bus ();

  instr_fetch_unit #(
    .ADDR_W   (16),
    .TIMEOUT  (16),
    .NOP_INSTR(Nop)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .flush           (flush),
    .trap_ack        (trap_ack),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .stall           (stall),
    .fetch_misaligned(fetch_misaligned),
    .fetch_fault     (fetch_fault),
    .mem             (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 16'h0000; flush = 1'b0; trap_ack = 1'b0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h0;
    tick(); tick(); tick();
    total++; if (instr !== Nop) begin bad++; $display("FAIL reset_instr got=%h want=%h", instr, Nop); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b want=1", stall); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_bus.mem_req); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fetch_fault); end
    rst = 1'b0;
    tick();
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL post_reset_req got=%b want=1", mem_bus.mem_req); end
    total++; if (mem_bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL post_reset_addr got=%h want=0000", mem_bus.mem_addr); end
  endtask

  // Continues the fetch of pc=0 launched at reset release; memory answers with zero waits.
  task automatic test_zero_wait();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0560_0513;
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid got=%b want=1", instr_valid); end
    total++; if (instr !== 32'h0560_0513) begin bad++; $display("FAIL zw_instr got=%h want=05600513", instr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL zw_stall got=%b want=0", stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL zw_hold_req[%0d] got=%b want=0", i, mem_bus.mem_req); end
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_hold_valid[%0d] got=%b want=1", i, instr_valid); end
    end
    mem_bus.mem_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    pc = 16'h0004;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ws_miss_valid got=%b want=0", instr_valid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0055_1073;
      end
      total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL ws_req[%0d] got=%b want=1", i, mem_bus.mem_req); end
      total++; if (mem_bus.mem_addr !== 16'h0004) begin bad++; $display("FAIL ws_addr[%0d] got=%h want=0004", i, mem_bus.mem_addr); end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL ws_stall[%0d] got=%b want=1", i, stall); end
      tick();
    end
    mem_bus.mem_ready = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ws_valid got=%b want=1", instr_valid); end
    total++; if (instr !== 32'h0055_1073) begin bad++; $display("FAIL ws_instr got=%h want=00551073", instr); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL ws_req_done got=%b want=0", mem_bus.mem_req); end
  endtask

  task automatic test_redirect();
    pc = 16'h0008;
    tick();
    tick();
    pc = 16'h0040;
    #1;
    total++; if (mem_bus.mem_addr !== 16'h0008) begin bad++; $display("FAIL rd_addr_hold got=%h want=0008", mem_bus.mem_addr); end
    tick();
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL rd_req_hold got=%b want=1", mem_bus.mem_req); end
    total++; if (mem_bus.mem_addr !== 16'h0008) begin bad++; $display("FAIL rd_addr_hold2 got=%h want=0008", mem_bus.mem_addr); end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hDEAD_0008;
    tick();
    mem_bus.mem_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_stale_valid got=%b want=0", instr_valid); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rd_idle_req got=%b want=0", mem_bus.mem_req); end
    tick();
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL rd_refetch_req got=%b want=1", mem_bus.mem_req); end
    total++; if (mem_bus.mem_addr !== 16'h0040) begin bad++; $display("FAIL rd_refetch_addr got=%h want=0040", mem_bus.mem_addr); end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0010_0093;
    tick();
    mem_bus.mem_ready = 1'b0;
    total++; if (instr !== 32'h0010_0093) begin bad++; $display("FAIL rd_instr got=%h want=00100093", instr); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b want=1", instr_valid); end
  endtask

  task automatic test_timeout();
    pc = 16'h0080;
    trap_ack = 1'b1;
    #1;
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL to_ack_ignored got=%b want=0", fetch_fault); end
    tick();
    trap_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (mem_bus.mem_req !== 1'b1 || fetch_fault !== 1'b0) begin
        bad++; $display("FAIL to_wait[%0d] req=%b fault=%b want req=1 fault=0", i, mem_bus.mem_req, fetch_fault);
      end
      tick();
    end
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%b want=1", fetch_fault); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL to_req got=%b want=0", mem_bus.mem_req); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL to_stall got=%b want=1", stall); end
    mem_bus.mem_ready = 1'b1;
    tick(); tick();
    mem_bus.mem_ready = 1'b0;
    total++; if (fetch_fault !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL to_hold fault=%b req=%b want fault=1 req=0", fetch_fault, mem_bus.mem_req);
    end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL to_release got=%b want=0", fetch_fault); end
    tick();
    total++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0080) begin
      bad++; $display("FAIL to_refetch req=%b addr=%h want req=1 addr=0080", mem_bus.mem_req, mem_bus.mem_addr);
    end
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
    tick();
    mem_bus.mem_ready = 1'b0;
    total++; if (instr !== 32'h1234_5678 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL to_instr got=%h/%b want=12345678/1", instr, instr_valid);
    end
  endtask

  task automatic test_misaligned();
    pc = 16'h0006;
    #1;
    total++; if (fetch_misaligned !== 1'b1) begin bad++; $display("FAIL ma_flag got=%b want=1", fetch_misaligned); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ma_stall got=%b want=1", stall); end
    tick(); tick();
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL ma_req got=%b want=0", mem_bus.mem_req); end
    pc = 16'h0080;
    #1;
    total++; if (fetch_misaligned !== 1'b0 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL ma_back mis=%b valid=%b want mis=0 valid=1", fetch_misaligned, instr_valid);
    end
  endtask

  task automatic test_flush();
    pc = 16'h0000;
    tick();
    mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h0560_0513;
    tick();
    total++; if (instr_valid !== 1'b1 || instr !== 32'h0560_0513) begin
      bad++; $display("FAIL fl_hit got=%h/%b want=05600513/1", instr, instr_valid);
    end
    flush = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || instr !== Nop) begin
      bad++; $display("FAIL fl_mask got=%h/%b want=00000013/0", instr, instr_valid);
    end
    tick();
    flush = 1'b0; mem_bus.mem_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL fl_cleared valid=%b req=%b want 0/0", instr_valid, mem_bus.mem_req);
    end
    tick();
    total++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin
      bad++; $display("FAIL fl_refetch req=%b addr=%h want 1/0000", mem_bus.mem_req, mem_bus.mem_addr);
    end
    // flush coinciding with completion discards the returned word
    flush = 1'b1; mem_bus.mem_ready = 1'b1;
    tick();
    flush = 1'b0; mem_bus.mem_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL fl_ready valid=%b req=%b want 0/0", instr_valid, mem_bus.mem_req);
    end
    tick();
    total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL fl_refetch2 got=%b want=1", mem_bus.mem_req); end
  endtask

  task automatic test_reset_mid_wait();
    rst = 1'b1;
    #1;
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_wait_req got=%b want=0", mem_bus.mem_req); end
    total++; if (instr_valid !== 1'b0 || stall !== 1'b1) begin
      bad++; $display("FAIL rst_wait_out valid=%b stall=%b want 0/1", instr_valid, stall);
    end
    tick();
    rst = 1'b0;
    tick();
    total++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin
      bad++; $display("FAIL rst_wait_refetch req=%b addr=%h want 1/0000", mem_bus.mem_req, mem_bus.mem_addr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_timeout();
    test_misaligned();
    test_flush();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
